// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner.
//   - keypad_state_e : scanner FSM states
//   - COL_W/ROW_W/CODE_W : matrix and key code widths
//   - SCAN_DIV_DEF / DEBOUNCE_CNT_DEF : default dwell and debounce settings
//   - lowest_row() : index of the lowest active row in an active-high pattern
package keypad_pkg;

  localparam int COL_W            = 4;
  localparam int ROW_W            = 4;
  localparam int CODE_W           = 4;
  localparam int SCAN_DIV_DEF     = 1000;
  localparam int DEBOUNCE_CNT_DEF = 4;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2
  } keypad_state_e;

  // Scans from the top down so the lowest set bit wins.
  function automatic logic [1:0] lowest_row(input logic [ROW_W-1:0] act);
    lowest_row = 2'd0;
    for (int r = ROW_W - 1; r >= 0; r--) begin
      if (act[r]) lowest_row = r[1:0];
    end
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Column dwell prescaler: pulses tick for one Clk cycle every SCAN_DIV cycles.
// The first tick after reset lands on the last cycle of the first dwell.
//   Clk   : clock
//   Reset : asynchronous active-low reset
//   en    : count enable
//   tick  : one-cycle pulse on the last cycle of each dwell
module keypad_tick_gen
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt <= RELOAD;
    end else if (en) begin
      if (cnt == '0) cnt <= RELOAD;
      else           cnt <= cnt - CNT_W'(1);
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and a valid/ack key handshake.
//   Clk       : clock
//   Reset     : asynchronous active-low reset
//   row_in    : keypad rows, active-low, asynchronous
//   col_out   : column drive, active-low one-hot
//   key_code  : accepted key, row*4+col
//   key_valid : key_code holds an unconsumed key
//   key_ack   : consumer acknowledge
//   overrun   : a key was accepted while the previous one was still pending
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_SCAN     | stepping columns, one per tick, until a row is active
// ST_DEBOUNCE | column frozen, counting identical samples of the pattern
// ST_HOLD     | key accepted, column frozen, counting release samples
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = SCAN_DIV_DEF,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ROW_W-1:0]  row_in,
  output logic [COL_W-1:0]  col_out,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ack,
  output logic              overrun
);

  localparam int DB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CNT - 1);

  logic [ROW_W-1:0] row_meta, row_sync, row_act;
  logic             any_act;
  logic             tick;

  keypad_state_e    state, state_nxt;
  logic [1:0]       col_idx, col_idx_nxt;
  logic [ROW_W-1:0] pat, pat_nxt;
  logic [DB_W-1:0]  db_cnt, db_cnt_nxt;
  logic             accept;
  logic [CODE_W-1:0] new_code;

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (1'b1),
    .tick  (tick)
  );

  // Synchronizer resets to the idle (released) row level.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  assign row_act = ~row_sync;
  assign any_act = |row_act;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= ST_SCAN;
      col_idx <= 2'd0;
      pat     <= '0;
      db_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      col_idx <= col_idx_nxt;
      pat     <= pat_nxt;
      db_cnt  <= db_cnt_nxt;
    end
  end

  // The counter is cleared on acceptance so HOLD can reuse it for release.
  always_comb begin
    state_nxt   = state;
    col_idx_nxt = col_idx;
    pat_nxt     = pat;
    db_cnt_nxt  = db_cnt;
    accept      = 1'b0;
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (any_act) begin
            pat_nxt    = row_act;
            db_cnt_nxt = '0;
            state_nxt  = ST_DEBOUNCE;
          end else begin
            col_idx_nxt = col_idx + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (row_act == pat) begin
            if (db_cnt == DB_LAST) begin
              accept     = 1'b1;
              db_cnt_nxt = '0;
              state_nxt  = ST_HOLD;
            end else begin
              db_cnt_nxt = db_cnt + DB_W'(1);
            end
          end else begin
            db_cnt_nxt  = '0;
            state_nxt   = ST_SCAN;
            col_idx_nxt = col_idx + 2'd1;
          end
        end
        ST_HOLD: begin
          if (any_act) begin
            db_cnt_nxt = '0;
          end else if (db_cnt == DB_LAST) begin
            db_cnt_nxt  = '0;
            state_nxt   = ST_SCAN;
            col_idx_nxt = col_idx + 2'd1;
          end else begin
            db_cnt_nxt = db_cnt + DB_W'(1);
          end
        end
        default: state_nxt = ST_SCAN;
      endcase
    end
  end

  assign new_code = {lowest_row(pat), col_idx};
  assign col_out  = ~(COL_W'(1) << col_idx);

  // An ack arriving with an acceptance lets the new key replace the old one.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (accept) begin
      if (!key_valid || key_ack) begin
        key_code  <= new_code;
        key_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (key_ack && key_valid) begin
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       overrun;

  logic [15:0] pressed = '0;
  logic [3:0]  exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .overrun   (overrun)
  );

  always #5 Clk = ~Clk;

  // Keypad matrix: a pressed key (r,c) pulls row r low while column c is driven.
  always_comb begin
    for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask

  // Returns at the first negedge (+1) of a fresh dwell on column c.
  task automatic wait_col(input int c, output bit ok);
    logic [3:0] tgt;
    bit seen_other;
    tgt = ~(4'b0001 << c);
    seen_other = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge Clk);
      #1;
      if (col_out != tgt) seen_other = 1'b1;
      else if (seen_other) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // n = number of negedges until key_valid is seen high, 0 on timeout.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge Clk);
      #1;
      if (key_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    idle(3);
    n_checks++; if (col_out !== 4'b1110) begin n_fail++; $display("FAIL reset_col_out: got %b want 1110", col_out); end
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
    n_checks++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_key_code: got %h want 0", key_code); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_scan;
    logic [3:0] exp;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      exp = ~(4'b0001 << (i / 4));
      n_checks++;
      if (col_out !== exp) begin n_fail++; $display("FAIL scan_col_out[%0d]: got %b want %b", i, col_out, exp); end
      if (key_valid !== 1'b0) begin n_fail++; $display("FAIL scan_key_valid[%0d]: got %b want 0", i, key_valid); end
      @(negedge Clk);
      #1;
    end
  endtask

  task automatic test_press_ack;
    bit ok;
    int n;
    logic [3:0] exp;
    wait_col(1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL press_wait_col1: got timeout want column 1"); end
    pressed[9] = 1'b1;
    exp_q.push_back(4'h9);
    wait_valid(40, n);
    n_checks++; if (n != 12) begin n_fail++; $display("FAIL press_latency: got %0d want 12 cycles", n); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
    n_checks++; if (key_code !== exp) begin n_fail++; $display("FAIL press_key_code: got %h want %h", key_code, exp); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL press_overrun: got %b want 0", overrun); end
    key_ack = 1'b1;
    @(negedge Clk);
    #1;
    key_ack = 1'b0;
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL press_ack_clear: got %b want 0", key_valid); end
    idle(10);
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL press_held_no_repeat: got %b want 0", key_valid); end
    pressed = '0;
    idle(24);
  endtask

  task automatic test_glitch;
    bit ok;
    bit seen;
    wait_col(0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL glitch_wait_col0: got timeout want column 0"); end
    pressed[0] = 1'b1;
    repeat (3) @(negedge Clk);
    #1;
    pressed[0] = 1'b0;
    repeat (4) @(negedge Clk);
    #1;
    n_checks++; if (col_out !== 4'b1110) begin n_fail++; $display("FAIL glitch_col_frozen: got %b want 1110", col_out); end
    @(negedge Clk);
    #1;
    n_checks++; if (col_out !== 4'b1101) begin n_fail++; $display("FAIL glitch_col_resume: got %b want 1101", col_out); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      #1;
      if (key_valid) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL glitch_key_valid: got 1 want 0"); end
  endtask

  task automatic test_overrun;
    bit ok;
    int n;
    logic [3:0] exp;
    wait_col(1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovr_wait_col1: got timeout want column 1"); end
    pressed[5] = 1'b1;
    exp_q.push_back(4'h5);
    wait_valid(40, n);
    n_checks++; if (n != 12) begin n_fail++; $display("FAIL ovr_latency: got %0d want 12 cycles", n); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
    n_checks++; if (key_code !== exp) begin n_fail++; $display("FAIL ovr_first_code: got %h want %h", key_code, exp); end
    pressed = '0;
    idle(24);
    wait_col(2, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovr_wait_col2: got timeout want column 2"); end
    pressed[10] = 1'b1;   // dropped key: nothing is expected on the scoreboard
    idle(16);
    n_checks++; if (key_code !== 4'h5) begin n_fail++; $display("FAIL ovr_code_stable: got %h want 5", key_code); end
    n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", key_valid); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    key_ack = 1'b1;
    @(negedge Clk);
    #1;
    key_ack = 1'b0;
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_valid: got %b want 0", key_valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_flag: got %b want 0", overrun); end
    pressed = '0;
    idle(24);
  endtask

  task automatic test_back_to_back;
    bit ok;
    int n;
    logic [3:0] exp;
    wait_col(3, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_wait_col3a: got timeout want column 3"); end
    pressed[3] = 1'b1;
    exp_q.push_back(4'h3);
    wait_valid(40, n);
    n_checks++; if (n != 12) begin n_fail++; $display("FAIL b2b_latency: got %0d want 12 cycles", n); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
    n_checks++; if (key_code !== exp) begin n_fail++; $display("FAIL b2b_first_code: got %h want %h", key_code, exp); end
    pressed = '0;
    idle(24);
    wait_col(3, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_wait_col3b: got timeout want column 3"); end
    pressed[3] = 1'b1;
    exp_q.push_back(4'h3);
    repeat (11) @(negedge Clk);
    #1;
    key_ack = 1'b1;       // lands on the acceptance edge
    @(negedge Clk);
    #1;
    key_ack = 1'b0;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
    n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", key_valid); end
    n_checks++; if (key_code !== exp) begin n_fail++; $display("FAIL b2b_code: got %h want %h", key_code, exp); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    key_ack = 1'b1;
    @(negedge Clk);
    #1;
    key_ack = 1'b0;
    pressed = '0;
    idle(24);
  endtask

  task automatic test_reset_hold;
    bit ok;
    int n;
    logic [3:0] exp;
    wait_col(2, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_wait_col2: got timeout want column 2"); end
    pressed[6] = 1'b1;
    exp_q.push_back(4'h6);
    wait_valid(40, n);
    n_checks++; if (n != 12) begin n_fail++; $display("FAIL rst_first_latency: got %0d want 12 cycles", n); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
    n_checks++; if (key_code !== exp) begin n_fail++; $display("FAIL rst_first_code: got %h want %h", key_code, exp); end
    idle(3);
    Reset = 1'b0;
    #1;
    n_checks++; if (col_out !== 4'b1110) begin n_fail++; $display("FAIL rst_hold_col_out: got %b want 1110", col_out); end
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_key_valid: got %b want 0", key_valid); end
    n_checks++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL rst_hold_key_code: got %h want 0", key_code); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_hold_overrun: got %b want 0", overrun); end
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    exp_q.push_back(4'h6);
    wait_valid(40, n);
    n_checks++; if (n != 20) begin n_fail++; $display("FAIL rst_reaccept_latency: got %0d want 20 cycles", n); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
    n_checks++; if (key_code !== exp) begin n_fail++; $display("FAIL rst_reaccept_code: got %h want %h", key_code, exp); end
    key_ack = 1'b1;
    @(negedge Clk);
    #1;
    key_ack = 1'b0;
    pressed = '0;
    idle(24);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_scan();
    test_press_ack();
    test_glitch();
    test_overrun();
    test_back_to_back();
    test_reset_hold();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, Clk cycles per column dwell (minimum 4).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4, consecutive identical samples required to accept a press or a release (minimum 1).
REQ-003 Port Clk  input  1  sole clock; all flops on rising edge.
REQ-004 Port Reset  input  1  asynchronous, active-low reset.
REQ-005 Port row_in  input  4  keypad rows; active-low, pulled up, asynchronous to Clk.
REQ-006 Port col_out  output  4  column drive; active-low one-hot.
REQ-007 Port key_code  output  4  accepted key, encoded row*4+col.
REQ-008 Port key_valid  output  1  key_code holds an unconsumed key.
REQ-009 Port key_ack  input  1  consumer acknowledge, sampled on Clk edge.
REQ-010 Port overrun  output  1  a press was dropped while key_valid=1.

Function
REQ-011 row_in SHALL pass through a 2-flop synchronizer; all row decisions use the synchronized value.
REQ-012 A tick SHALL assert for one cycle every SCAN_DIV cycles; rows SHALL be sampled only on tick, i.e. on the last cycle of a column dwell.
REQ-013 States SHALL be SCAN, DEBOUNCE and HOLD.
REQ-014 SCAN: on a tick with no active row, the column index advances 0->1->2->3->0; col_out = ~(1<<index).
REQ-015 SCAN: on a tick with any row active, the block latches the row pattern and column index, clears the debounce count and enters DEBOUNCE; the column stays frozen.
REQ-016 DEBOUNCE: on each tick, a pattern equal to the latched pattern increments the count; a different pattern clears the count and returns to SCAN with the column advancing.
REQ-017 DEBOUNCE: when the count reaches DEBOUNCE_CNT, the key SHALL be accepted and the state SHALL move to HOLD.
REQ-018 For multiple active rows, the lowest-index active row SHALL form key_code[3:2]; the column index SHALL form key_code[1:0].
REQ-019 Acceptance with key_valid=0 SHALL load key_code and set key_valid on the next edge.
REQ-020 Acceptance with key_valid=1 and key_ack=0 SHALL leave key_code unchanged and set overrun.
REQ-021 Acceptance coinciding with key_ack=1 SHALL load the new key_code, keep key_valid=1 and leave overrun unchanged.
REQ-022 key_ack=1 with no acceptance SHALL clear key_valid and overrun on the next edge; key_ack with key_valid=0 has no effect.
REQ-023 key_code SHALL be stable while key_valid=1, except as allowed by REQ-021.
REQ-024 HOLD: the column stays frozen; after DEBOUNCE_CNT consecutive ticks with no active row, the state returns to SCAN and the column advances. Any active sample in HOLD restarts the release count.
REQ-025 Press-to-valid latency SHALL be (DEBOUNCE_CNT+1) ticks after the first active sample of the pressed column, plus 1 cycle.

Reset
REQ-026 Reset low SHALL immediately force SCAN state, column index 0, col_out=4'b1110, key_code=0, key_valid=0, overrun=0, and clear all counters and synchronizer flops.
REQ-027 Reset mid-DEBOUNCE or mid-HOLD SHALL discard the pending key; no key_valid is produced after release until a fresh full debounce.

Structure
REQ-028 A shared package keypad_pkg SHALL hold the state enum, the COL_W/ROW_W/CODE_W constants and the default SCAN_DIV/DEBOUNCE_CNT values.
REQ-029 The prescaler SHALL be the sub-module keypad_tick_gen (parameter SCAN_DIV; ports Clk, Reset, en, tick). The FSM, synchronizer and handshake remain in keypad_scanner.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=2)
REQ-030 Reset release, no press -> col_out cycles 1110,1101,1011,0111 every 4 Clk; key_valid stays 0.
REQ-031 Hold row 2 low while column 1 is driven, held well beyond the debounce period -> key_code=4'h9, key_valid=1 within 3 ticks + 1 cycle plus synchronizer delay of the first active sample; ack -> key_valid=0 next edge.
REQ-032 Single-tick glitch on row 0 -> no key_valid; scanning resumes at the next column.
REQ-033 Press key 5, no ack, release, press key 0xA -> key_code stays 4'h5 and overrun=1; ack -> both cleared.
REQ-034 Press 3, release, press 3 again with key_ack asserted on the acceptance cycle -> key_valid remains 1 with key_code=4'h3 and overrun=0.
REQ-035 Reset asserted in HOLD while a key is still pressed -> outputs return to reset values immediately; the held key is re-accepted only after a full debounce.
